// File: rtl/proc_pkg.sv
// Shared encodings for the lab-10 processor control unit: opcodes, branch
// conditions, bus select codes, ALU operations and controller states.
package proc_pkg;

  typedef enum logic [2:0] {
    OP_MV  = 3'd0,
    OP_MVT = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_LD  = 3'd4,
    OP_ST  = 3'd5,
    OP_AND = 3'd6,
    OP_B   = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    CC_AL = 3'd0,
    CC_EQ = 3'd1,
    CC_NE = 3'd2,
    CC_CC = 3'd3,
    CC_CS = 3'd4,
    CC_PL = 3'd5,
    CC_MI = 3'd6,
    CC_NV = 3'd7
  } cond_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOADIR,
    S_EX1,
    S_EX2,
    S_EX3
  } state_e;

  localparam logic [3:0] SEL_PC  = 4'd7;
  localparam logic [3:0] SEL_G   = 4'd8;
  localparam logic [3:0] SEL_DIN = 4'd9;
  localparam logic [3:0] SEL_DZX = 4'd10;
  localparam logic [3:0] SEL_DHI = 4'd11;
  localparam logic [3:0] SEL_DSX = 4'd12;

  localparam logic [7:0] R_PC = 8'h80;

endpackage

// File: rtl/proc_ctrl_if.sv
// Control/status bundle between the control unit (master) and the datapath (slave).
interface proc_ctrl_if;
  logic        Run;
  logic [15:0] IR;
  logic        Z;
  logic        N;
  logic        C;
  logic [3:0]  Sel;
  logic [7:0]  R_in;
  logic        A_in;
  logic        G_in;
  logic        F_in;
  logic [1:0]  AluOp;
  logic        ADDR_in;
  logic        DOUT_in;
  logic        W_D;
  logic        IR_in;
  logic        pc_incr;
  logic        Done;

  modport master (
    input  Run, IR, Z, N, C,
    output Sel, R_in, A_in, G_in, F_in, AluOp, ADDR_in, DOUT_in, W_D,
           IR_in, pc_incr, Done
  );

  modport slave (
    output Run, IR, Z, N, C,
    input  Sel, R_in, A_in, G_in, F_in, AluOp, ADDR_in, DOUT_in, W_D,
           IR_in, pc_incr, Done
  );
endinterface

// File: rtl/proc_decode.sv
// Instruction field split, one-hot rX and branch-condition evaluation.
module proc_decode
  import proc_pkg::*;
(
  input  logic [15:0] IR,
  input  logic        Z,
  input  logic        N,
  input  logic        C,
  output opcode_e     op,
  output logic        imm,
  output logic [2:0]  rx,
  output logic [2:0]  ry,
  output logic [7:0]  rx_oh,
  output logic        cond_true
);

  // D is consumed by the datapath only; fold the unused bits here.
  logic unused_d;
  assign unused_d = ^IR[8:3];

  assign op    = opcode_e'(IR[15:13]);
  assign imm   = IR[12];
  assign rx    = IR[11:9];
  assign ry    = IR[2:0];
  assign rx_oh = 8'd1 << rx;

  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(rx))
      CC_AL:   cond_true = 1'b1;
      CC_EQ:   cond_true = Z;
      CC_NE:   cond_true = ~Z;
      CC_CC:   cond_true = ~C;
      CC_CS:   cond_true = C;
      CC_PL:   cond_true = ~N;
      CC_MI:   cond_true = N;
      CC_NV:   cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/proc_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the lab-10 16-bit datapath.
module proc_ctrl
  import proc_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  proc_ctrl_if.master bus
);

  localparam logic [1:0] WAIT_LOAD = 2'(MEM_WAIT);

  state_e     state, state_nx;
  logic [1:0] wait_cnt, wait_nx;

  opcode_e    op;
  logic       imm;
  logic [2:0] rx, ry;
  logic [7:0] rx_oh;
  logic       cond_true;

  logic [3:0] sel;
  logic [7:0] r_in;
  logic       a_in, g_in, f_in, addr_in, dout_in, w_d, ir_in, pc_incr, done;
  alu_op_e    alu_op;

  proc_decode u_decode (
    .IR       (bus.IR),
    .Z        (bus.Z),
    .N        (bus.N),
    .C        (bus.C),
    .op       (op),
    .imm      (imm),
    .rx       (rx),
    .ry       (ry),
    .rx_oh    (rx_oh),
    .cond_true(cond_true)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
    end
  end

  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    sel      = '0;
    r_in     = '0;
    a_in     = 1'b0;
    g_in     = 1'b0;
    f_in     = 1'b0;
    alu_op   = ALU_ADD;
    addr_in  = 1'b0;
    dout_in  = 1'b0;
    w_d      = 1'b0;
    ir_in    = 1'b0;
    pc_incr  = 1'b0;
    done     = 1'b0;

    case (state)
      S_IDLE: if (bus.Run) state_nx = S_FETCH;

      S_FETCH: begin
        sel      = SEL_PC;
        addr_in  = 1'b1;
        pc_incr  = 1'b1;
        wait_nx  = WAIT_LOAD;
        state_nx = S_WAIT;
      end

      S_WAIT: begin
        if (wait_cnt <= 2'd1) state_nx = S_LOADIR;
        else                  wait_nx  = wait_cnt - 2'd1;
      end

      S_LOADIR: begin
        ir_in    = 1'b1;
        state_nx = S_EX1;
      end

      S_EX1: begin
        case (op)
          OP_MV: begin
            sel  = imm ? SEL_DZX : {1'b0, ry};
            r_in = rx_oh;
            done = 1'b1;
          end
          OP_MVT: begin
            if (imm) begin
              sel  = SEL_DHI;
              r_in = rx_oh;
            end
            done = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            sel      = {1'b0, rx};
            a_in     = 1'b1;
            state_nx = S_EX2;
          end
          OP_LD, OP_ST: begin
            if (imm) begin
              done = 1'b1;
            end else begin
              sel      = {1'b0, ry};
              addr_in  = 1'b1;
              wait_nx  = WAIT_LOAD;
              state_nx = S_EX2;
            end
          end
          OP_B: begin
            if (cond_true) begin
              sel      = SEL_PC;
              a_in     = 1'b1;
              state_nx = S_EX2;
            end else begin
              done = 1'b1;
            end
          end
        endcase
      end

      S_EX2: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND: begin
            sel      = imm ? SEL_DZX : {1'b0, ry};
            g_in     = 1'b1;
            f_in     = 1'b1;
            alu_op   = (op == OP_ADD) ? ALU_ADD : (op == OP_SUB) ? ALU_SUB : ALU_AND;
            state_nx = S_EX3;
          end
          OP_LD: begin
            if (wait_cnt <= 2'd1) state_nx = S_EX3;
            else                  wait_nx  = wait_cnt - 2'd1;
          end
          OP_ST: begin
            sel     = {1'b0, rx};
            dout_in = 1'b1;
            w_d     = 1'b1;
            done    = 1'b1;
          end
          OP_B: begin
            sel      = SEL_DSX;
            g_in     = 1'b1;
            alu_op   = ALU_ADD;
            state_nx = S_EX3;
          end
          default: state_nx = S_IDLE;
        endcase
      end

      S_EX3: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND: begin
            sel  = SEL_G;
            r_in = rx_oh;
            done = 1'b1;
          end
          OP_B: begin
            sel  = SEL_G;
            r_in = R_PC;
            done = 1'b1;
          end
          OP_LD: begin
            sel  = SEL_DIN;
            r_in = rx_oh;
            done = 1'b1;
          end
          default: state_nx = S_IDLE;
        endcase
      end

      default: state_nx = S_IDLE;
    endcase

    // Run is only consulted once the instruction completes, so dropping it never aborts.
    if (done) state_nx = bus.Run ? S_FETCH : S_IDLE;
  end

  assign bus.Sel     = sel;
  assign bus.R_in    = r_in;
  assign bus.A_in    = a_in;
  assign bus.G_in    = g_in;
  assign bus.F_in    = f_in;
  assign bus.AluOp   = alu_op;
  assign bus.ADDR_in = addr_in;
  assign bus.DOUT_in = dout_in;
  assign bus.W_D     = w_d;
  assign bus.IR_in   = ir_in;
  assign bus.pc_incr = pc_incr;
  assign bus.Done    = done;

endmodule

// File: tb/tb_proc_ctrl.sv
// Bench for proc_ctrl: per-instruction expected output traces built from the
// instruction rules, compared against the DUT on every falling clock edge.
module tb_proc_ctrl;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] r_in;
    logic       a_in;
    logic       g_in;
    logic       f_in;
    logic [1:0] alu_op;
    logic       addr_in;
    logic       dout_in;
    logic       w_d;
    logic       ir_in;
    logic       pc_incr;
    logic       done;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [15:0] ir = '0;
  logic        fz = 1'b0, fn = 1'b0, fc = 1'b0;
  logic        use3 = 1'b0;
  logic        chk_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  outs_t exp_q[$];
  outs_t tq[$];
  outs_t got1, got3, got;

  proc_ctrl_if bus1 ();
  proc_ctrl_if bus3 ();

  assign bus1.Run = run & ~use3;
  assign bus3.Run = run & use3;
  assign bus1.IR = ir;
  assign bus3.IR = ir;
  assign bus1.Z = fz;
  assign bus3.Z = fz;
  assign bus1.N = fn;
  assign bus3.N = fn;
  assign bus1.C = fc;
  assign bus3.C = fc;

  proc_ctrl #(.MEM_WAIT(1)) dut1 (.Clock(clk), .Reset(rst), .bus(bus1));
  proc_ctrl #(.MEM_WAIT(3)) dut3 (.Clock(clk), .Reset(rst), .bus(bus3));

  assign got1 = {bus1.Sel, bus1.R_in, bus1.A_in, bus1.G_in, bus1.F_in, bus1.AluOp,
                 bus1.ADDR_in, bus1.DOUT_in, bus1.W_D, bus1.IR_in, bus1.pc_incr, bus1.Done};
  assign got3 = {bus3.Sel, bus3.R_in, bus3.A_in, bus3.G_in, bus3.F_in, bus3.AluOp,
                 bus3.ADDR_in, bus3.DOUT_in, bus3.W_D, bus3.IR_in, bus3.pc_incr, bus3.Done};
  assign got = use3 ? got3 : got1;

  always #5 clk = ~clk;

  always @(negedge clk) begin : compare
    outs_t e;
    if (chk_en) begin
      e = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      n_checks++;
      if (got === e) n_pass++;
      else $display("FAIL outputs t=%0t got=%h exp=%h", $time, got, e);
    end
  end

  task automatic chk(input string name, input logic [31:0] g, input logic [31:0] e);
    n_checks++;
    if (g === e) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, g, e);
  endtask

  function automatic logic taken(input logic [2:0] cc, input logic z, input logic n, input logic c);
    case (cc)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return !c;
      3'd4: return c;
      3'd5: return !n;
      3'd6: return n;
      default: return 1'b0;
    endcase
  endfunction

  // Cycle-by-cycle outputs of one instruction, optionally preceded by idle cycles.
  task automatic build_trace(input logic [15:0] w, input logic z, input logic n, input logic c,
                             input int mw, input int lead);
    outs_t v;
    logic [2:0] op, rx, ry;
    logic imm;
    logic [7:0] dst;
    op = w[15:13]; imm = w[12]; rx = w[11:9]; ry = w[2:0];
    dst = 8'd1 << rx;
    tq.delete();
    v = '0;
    for (int i = 0; i < lead; i++) tq.push_back(v);
    v.sel = 4'd7; v.addr_in = 1'b1; v.pc_incr = 1'b1; tq.push_back(v);
    v = '0;
    for (int i = 0; i < mw; i++) tq.push_back(v);
    v.ir_in = 1'b1; tq.push_back(v);
    v = '0;
    case (op)
      3'd0: begin
        v.sel = imm ? 4'd10 : {1'b0, ry}; v.r_in = dst; v.done = 1'b1; tq.push_back(v);
      end
      3'd1: begin
        if (imm) begin v.sel = 4'd11; v.r_in = dst; end
        v.done = 1'b1; tq.push_back(v);
      end
      3'd2, 3'd3, 3'd6: begin
        v.sel = {1'b0, rx}; v.a_in = 1'b1; tq.push_back(v);
        v = '0; v.sel = imm ? 4'd10 : {1'b0, ry}; v.g_in = 1'b1; v.f_in = 1'b1;
        v.alu_op = (op == 3'd2) ? 2'd0 : (op == 3'd3) ? 2'd1 : 2'd2; tq.push_back(v);
        v = '0; v.sel = 4'd8; v.r_in = dst; v.done = 1'b1; tq.push_back(v);
      end
      3'd4, 3'd5: begin
        if (imm) begin
          v.done = 1'b1; tq.push_back(v);
        end else begin
          v.sel = {1'b0, ry}; v.addr_in = 1'b1; tq.push_back(v);
          v = '0;
          if (op == 3'd4) begin
            for (int i = 0; i < mw; i++) tq.push_back(v);
            v.sel = 4'd9; v.r_in = dst; v.done = 1'b1; tq.push_back(v);
          end else begin
            v.sel = {1'b0, rx}; v.dout_in = 1'b1; v.w_d = 1'b1; v.done = 1'b1; tq.push_back(v);
          end
        end
      end
      default: begin
        if (taken(rx, z, n, c)) begin
          v.sel = 4'd7; v.a_in = 1'b1; tq.push_back(v);
          v = '0; v.sel = 4'd12; v.g_in = 1'b1; tq.push_back(v);
          v = '0; v.sel = 4'd8; v.r_in = 8'h80; v.done = 1'b1; tq.push_back(v);
        end else begin
          v.done = 1'b1; tq.push_back(v);
        end
      end
    endcase
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout got=%0d exp=0 entries left", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Runs one instruction; Run takes next_run while the instruction sits in EX1.
  task automatic run_instr(input logic [15:0] w, input logic z, input logic n, input logic c,
                           input logic next_run);
    int mw, lead;
    mw = use3 ? 3 : 1;
    lead = run ? 0 : 1;
    build_trace(w, z, n, c, mw, lead);
    ir = w; fz = z; fn = n; fc = c; run = 1'b1;
    foreach (tq[i]) exp_q.push_back(tq[i]);
    repeat (lead + mw + 2) @(posedge clk);
    #1 run = next_run;
    drain();
  endtask

  initial begin
    #1;
    chk("reset_outs", 32'(got1), 32'd0);
    chk("reset_outs3", 32'(got3), 32'd0);

    build_trace(16'h1405, 0, 0, 0, 1, 0);
    chk("mdl_mv_len", tq.size(), 4);
    chk("mdl_mv_sel", tq[3].sel, 10);
    chk("mdl_mv_rin", tq[3].r_in, 8'h04);
    chk("mdl_mv_done", tq[3].done, 1);
    build_trace(16'h4203, 0, 0, 0, 1, 0);
    chk("mdl_add_len", tq.size(), 6);
    chk("mdl_add_ex2", {tq[4].sel, tq[4].g_in, tq[4].f_in, tq[4].alu_op}, {4'd3, 1'b1, 1'b1, 2'd0});
    chk("mdl_add_ex3", {tq[5].sel, tq[5].r_in}, {4'd8, 8'h02});
    build_trace(16'h6203, 0, 0, 0, 1, 0);
    chk("mdl_sub_op", tq[4].alu_op, 1);
    build_trace(16'h8805, 0, 0, 0, 3, 0);
    chk("mdl_ld3_len", tq.size(), 10);
    chk("mdl_ld3_ex3", {tq[9].sel, tq[9].r_in}, {4'd9, 8'h10});
    build_trace(16'hE3FE, 1, 0, 0, 1, 0);
    chk("mdl_beq_t", {tq.size(), tq[4].sel, tq[5].r_in}, {6, 4'd12, 8'h80});
    build_trace(16'hE3FE, 0, 0, 0, 1, 0);
    chk("mdl_beq_nt", {tq.size(), tq[3].r_in, tq[3].done}, {4, 8'h00, 1'b1});

    @(posedge clk); #1 rst = 1'b0; chk_en = 1'b1;

    run_instr(16'h1405, 0, 0, 0, 1);   // mv R2,#5
    run_instr(16'h4203, 0, 0, 0, 1);   // add R1,R3
    run_instr(16'h6203, 0, 0, 0, 1);   // sub R1,R3
    run_instr(16'hD203, 0, 0, 0, 1);   // and R1,#3
    run_instr(16'h3612, 0, 0, 0, 1);   // mvt R3,#0x12
    run_instr(16'h2612, 0, 0, 0, 1);   // mvt imm=0 -> nop
    run_instr(16'hE3FE, 1, 0, 0, 1);   // beq taken
    run_instr(16'hE3FE, 0, 0, 0, 1);   // beq not taken
    run_instr(16'hE604, 0, 0, 0, 1);   // bcc taken
    run_instr(16'hEC04, 0, 0, 1, 1);   // bmi not taken
    run_instr(16'hEE04, 1, 1, 1, 1);   // never
    run_instr(16'hE004, 0, 0, 0, 1);   // always
    run_instr(16'h9805, 0, 0, 0, 1);   // ld imm=1 -> nop
    run_instr(16'h8805, 0, 0, 0, 1);   // ld R4,[R5]
    run_instr(16'hA006, 0, 0, 0, 0);   // st R0,[R6], Run dropped in EX1
    repeat (3) @(posedge clk);
    #1;

    use3 = 1'b1;
    @(posedge clk); #1;
    run_instr(16'h8805, 0, 0, 0, 1);   // ld with MEM_WAIT=3
    run_instr(16'h0E01, 0, 0, 0, 0);   // mv R7,R1
    repeat (2) @(posedge clk);
    #1 use3 = 1'b0;

    // Reset in EX2 of add: run the prefix up to EX1, then assert reset mid-EX2.
    build_trace(16'h4203, 0, 0, 0, 1, 1);
    ir = 16'h4203; run = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(tq[i]);
    drain();
    chk("ex2_before_reset", {got1.sel, got1.g_in, got1.f_in}, {4'd3, 1'b1, 1'b1});
    #1 rst = 1'b1;
    #1 chk("reset_async", 32'(got1), 32'd0);
    @(posedge clk); #1;
    chk("reset_hold", 32'(got1), 32'd0);
    rst = 1'b0; run = 1'b0;
    run_instr(16'h1405, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/proc_ctrl.md
Name: proc_ctrl

Overview:
- Control unit for the lab-10 simple 16-bit processor datapath: eight registers R0–R7 (R7 = PC), A/G ALU registers, ADDR/DOUT registers, IR, flag register, synchronous memory.
- Sequences fetch/decode/execute over multiple cycles.
- Drives the bus mux select and every datapath load enable from the current state and the registered IR.
- Sits between the board-level wrapper (Run switch, reset key) and the datapath.

Parameters:
MEM_WAIT, 1, memory read latency in cycles after ADDR load before data is valid on DIN (legal 1..3).

Ports:
Clock  input  1  system clock; all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
Run  input  1  level; permits starting a new instruction fetch
IR  input  16  registered instruction word from the datapath IR
Z  input  1  flag: last ALU result zero
N  input  1  flag: last ALU result negative
C  input  1  flag: last ALU carry out / not-borrow
Sel  output  4  bus mux select: 0–7 = R0–R7, 8 = G, 9 = DIN, 10 = zero-extended D, 11 = D[7:0]<<8, 12 = sign-extended D
R_in  output  8  one-hot register load enables
A_in, G_in, F_in  output  1 each  load A, G, flags
AluOp  output  2  0 ADD, 1 SUB, 2 AND
ADDR_in, DOUT_in, W_D  output  1 each  load ADDR, load DOUT, memory write
IR_in  output  1  load IR from DIN
pc_incr  output  1  increment R7
Done  output  1  one-cycle pulse on the final cycle of each instruction

Behaviour:
- Instruction format: IR[15:13] opcode, IR[12] imm flag, IR[11:9] rX, IR[2:0] rY, IR[8:0] D.
- Opcodes: 0 mv, 1 mvt, 2 add, 3 sub, 4 ld, 5 st, 6 and, 7 b{cond}.
- Branch condition code in rX: 0 always, 1 eq (Z), 2 ne (!Z), 3 cc (!C), 4 cs (C), 5 pl (!N), 6 mi (N), 7 never.
- All outputs are combinational from state + IR. Every output not listed for a state is 0. IDLE drives all outputs 0.
- States: IDLE, FETCH, WAIT, LOADIR, EX1, EX2, EX3.
- IDLE: move to FETCH when Run=1, otherwise stay.
- FETCH: Sel=7, ADDR_in=1, pc_incr=1 -> WAIT.
- WAIT: counter loaded with MEM_WAIT; stay until it reaches 1 -> LOADIR.
- LOADIR: IR_in=1 -> EX1.
- EX1:
  - mv: Sel = imm ? 10 : rY; R_in[rX]=1; Done=1.
  - mvt: Sel=11; R_in[rX]=1; Done=1. mvt with imm=0 is a nop with Done=1.
  - add/sub/and: Sel=rX, A_in=1 -> EX2.
  - ld/st with imm=0: Sel=rY, ADDR_in=1 -> EX2. With imm=1: nop, Done=1.
  - b with condition true: Sel=7, A_in=1 -> EX2. Condition false: Done=1.
- EX2:
  - alu ops: Sel = imm ? 10 : rY; G_in=1; F_in=1; AluOp = add 0 / sub 1 / and 2 -> EX3.
  - ld: wait counter reloaded; stay until expired -> EX3.
  - st: Sel=rX, DOUT_in=1, W_D=1, Done=1.
  - b: Sel=12, G_in=1, AluOp=0 -> EX3.
- EX3:
  - alu ops and b: Sel=8, R_in = alu ? rX : R7; Done=1.
  - ld: Sel=9, R_in[rX]=1, Done=1.
- After any Done: next state is FETCH if Run=1, otherwise IDLE. Dropping Run mid-instruction never aborts the instruction.
- rX=7 as a destination is legal (jump); no special handling.
- Reset (any cycle, any state): state goes to IDLE and the wait counter clears, both immediately and asynchronously. No enable may be asserted after Reset rises.
- Flags are sampled only in EX1 of b.

Decomposition:
- Package proc_pkg holds: opcode constants, condition codes, Sel codes, AluOp codes, state encoding.
- One sub-module, proc_decode (combinational): splits IR into fields, generates one-hot rX, and evaluates the branch condition from Z/N/C.

Test Plan:
- MEM_WAIT=1, Run=1, IR=mv R2,#5 (0x1405) -> FETCH(Sel=7, ADDR_in, pc_incr), WAIT, LOADIR(IR_in), EX1(Sel=10, R_in=0x04, Done); 4 cycles per instruction.
- IR=add R1,R3 (0x4203) -> EX1 Sel=1 A_in; EX2 Sel=3 G_in F_in AluOp=0; EX3 Sel=8 R_in=0x02 Done; 6 cycles total. Repeat as sub 0x6203 -> AluOp=1.
- MEM_WAIT=3, IR=ld R4,[R5] (0x8805) -> WAIT holds 3 cycles; EX2 holds 3 cycles; EX3 Sel=9 R_in=0x10 Done.
- IR=beq #-2 (0xE3FE) with Z=1 -> EX2 Sel=12 G_in; EX3 Sel=8 R_in=0x80 Done. Same IR with Z=0 -> Done in EX1, R_in=0.
- st R0,[R6] (0xA006) with Run dropped during EX1 -> W_D=1 with Sel=0 in EX2 and Done, then IDLE with all outputs 0.
- Reset asserted in EX2 of add -> next cycle state IDLE, G_in/F_in/R_in=0; with Run=1 after release, fetch restarts at FETCH.
